ram_sequence_controller: RTL and testbench
==========================================

Name: ram_sequence_controller

Overview:
Sequencer for the 16x4 synchronous move RAM. The RAM has a registered address, so read data is valid one cycle after the address edge. The block has two modes:
- Playback: reads entries 0..limite in order and presents each 4-bit one-hot move for a fixed number of cycles to the drone simulator datapath.
- Record: writes one-hot button presses into consecutive addresses.
The block is the only master of the RAM port.

Parameters:
HOLD_CYCLES, 1000, cycles each move is held on movimento during playback (>=1)
CNT_W, 10, width of the hold counter; must satisfy 2^CNT_W >= HOLD_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
iniciar_reproducao  in  1  start playback; sampled only in IDLE
iniciar_gravacao  in  1  start record; sampled only in IDLE
parar  in  1  synchronous abort, any state
limite  in  4  last index of sequence (0..15), sampled at start
botoes  in  4  synchronized button levels, one-hot expected
ram_q  in  4  RAM read data
ram_we  out  1  RAM write enable
ram_addr  out  4  RAM address
ram_data  out  4  RAM write data
movimento  out  4  current move during playback, 0 otherwise
movimento_valido  out  1  high while movimento is valid
ocupado  out  1  high in every state except IDLE
fim  out  1  one-cycle pulse when a sequence completes
erro_botao  out  1  one-cycle pulse on a non-one-hot press

Behaviour:
- Reset (async): state IDLE, idx=0, lim_reg=0, counter=0. All outputs 0 (ram_addr=0, movimento=0, fim=0).
- ram_addr = idx combinationally. ram_we is high only in REC_WRITE. ram_data is the registered press value.
- States: IDLE, RD_SETUP, RD_LATCH, HOLD, REC_WAIT, REC_WRITE, DONE.
- IDLE:
  - iniciar_reproducao=1: idx=0, lim_reg=limite, go to RD_SETUP.
  - Else iniciar_gravacao=1: idx=0, lim_reg=limite, go to REC_WAIT.
  - Both high: playback wins.
  - Starts are ignored in all other states.
- RD_SETUP: address presented; the RAM registers it at this edge. Go to RD_LATCH.
- RD_LATCH: ram_q valid; capture into movimento; counter=0; go to HOLD.
- HOLD:
  - movimento_valido=1 for exactly HOLD_CYCLES cycles.
  - When counter==HOLD_CYCLES-1: clear movimento; if idx==lim_reg go to DONE, else idx+1 and go to RD_SETUP.
- Playback timing:
  - Per step: HOLD_CYCLES+2 cycles.
  - From start acceptance to fim: (lim_reg+1)*(HOLD_CYCLES+2) cycles, then fim in DONE.
  - A RAM value of 0000 is still presented with movimento_valido=1.
- REC_WAIT:
  - Rising-edge detect on botoes (register of previous value; prev cleared to 0 on entry).
  - New nonzero value that is one-hot: latch into ram_data, go to REC_WRITE.
  - Nonzero, not one-hot: erro_botao pulse, stay.
  - Held buttons do not retrigger.
- REC_WRITE: ram_we=1 for one cycle at ram_addr=idx. Then if idx==lim_reg go to DONE, else idx+1 and go to REC_WAIT.
- DONE: fim=1 for one cycle, idx=0, go to IDLE.
- parar=1 in any non-IDLE state:
  - Next state IDLE; idx=0, movimento=0, movimento_valido=0.
  - ram_we is forced 0 in that cycle; no write occurs even in REC_WRITE.
  - No fim pulse.
- parar has priority over every transition.
- idx never wraps: at most 16 steps with limite=15; the DONE check precedes increment.
- Reset asserted mid-operation: immediate return to the reset state, ram_we deasserted asynchronously. RAM contents written before reset persist.

Test Plan:
1. HOLD_CYCLES=4, RAM preloaded 0000,0010,0100,1000; limite=3, pulse iniciar_reproducao -> movimento shows 0000,0010,0100,1000, each with valid high 4 cycles, 2-cycle gaps; fim pulses 24 cycles after start; ocupado then drops.
2. Record with limite=1: press 0001 then 0100 -> ram_we pulses at addr 0 data 0001 and addr 1 data 0100; fim pulses; playback then returns 0001,0100.
3. In record, press 0011 and hold 0001 for 10 cycles -> erro_botao single pulse for 0011; exactly one write of 0001; no retrigger while held.
4. Both starts high in IDLE -> playback entered (ram_we stays 0). A start pulse during HOLD is ignored.
5. parar during HOLD of step 2, and again in REC_WRITE -> IDLE next cycle, movimento=0, no write, no fim.
6. Assert reset mid-playback asynchronously (between edges) -> all outputs 0 immediately. limite=15 playback completes 16 steps with no address wrap.

Source files
------------

// File: rtl/ram_sequence_controller_if.sv
// ram_sequence_controller_if: single-port move RAM bus between the sequencer and the RAM
interface ram_sequence_controller_if;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic [3:0] ram_q;
  modport master (output ram_we, output ram_addr, output ram_data, input ram_q);
  modport slave (input ram_we, input ram_addr, input ram_data, output ram_q);
endinterface

// File: rtl/ram_sequence_controller.sv
// ram_sequence_controller: plays back or records one-hot moves through a 16x4 synchronous RAM
module ram_sequence_controller #(
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              iniciar_reproducao,
  input  logic                              iniciar_gravacao,
  input  logic                              parar,
  input  logic [3:0]                        limite,
  input  logic [3:0]                        botoes,
  ram_sequence_controller_if.master         ram,
  output logic [3:0]                        movimento,
  output logic                              movimento_valido,
  output logic                              ocupado,
  output logic                              fim,
  output logic                              erro_botao
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_LATCH, HOLD, REC_WAIT, REC_WRITE, DONE} state_t;
  state_t           state;
  logic [3:0]       idx;
  logic [3:0]       lim_reg;
  logic [3:0]       prev;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt;
  logic             is_new;
  logic             one_hot;
  assign is_new = botoes != prev && botoes != 4'd0;
  assign one_hot = (botoes & (botoes - 4'd1)) == 4'd0;
  assign ram.ram_addr = idx;
  assign ram.ram_data = press;
  // an abort in the write cycle must suppress the write itself, so we is gated combinationally
  assign ram.ram_we = state == REC_WRITE && !parar;
  assign ocupado = state != IDLE;
  // sequencer: parar overrides every transition; prev persists across writes so held buttons never retrigger
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      lim_reg <= '0;
      prev <= '0;
      press <= '0;
      cnt <= '0;
      movimento <= '0;
      movimento_valido <= 1'b0;
      fim <= 1'b0;
      erro_botao <= 1'b0;
    end else begin
      fim <= 1'b0;
      erro_botao <= 1'b0;
      if (parar) begin
        state <= IDLE;
        idx <= '0;
        movimento <= '0;
        movimento_valido <= 1'b0;
      end else begin
        case (state)
          IDLE: if (iniciar_reproducao || iniciar_gravacao) begin
            idx <= '0;
            lim_reg <= limite;
            prev <= '0;
            state <= iniciar_reproducao ? RD_SETUP : REC_WAIT;
          end
          RD_SETUP: state <= RD_LATCH;
          RD_LATCH: begin
            movimento <= ram.ram_q;
            movimento_valido <= 1'b1;
            cnt <= '0;
            state <= HOLD;
          end
          HOLD: if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            movimento <= '0;
            movimento_valido <= 1'b0;
            fim <= idx == lim_reg;
            idx <= idx == lim_reg ? idx : idx + 4'd1;
            state <= idx == lim_reg ? DONE : RD_SETUP;
          end else cnt <= cnt + 1'b1;
          REC_WAIT: begin
            prev <= botoes;
            press <= is_new && one_hot ? botoes : press;
            erro_botao <= is_new && !one_hot;
            state <= is_new && one_hot ? REC_WRITE : REC_WAIT;
          end
          REC_WRITE: begin
            prev <= botoes;
            fim <= idx == lim_reg;
            idx <= idx == lim_reg ? idx : idx + 4'd1;
            state <= idx == lim_reg ? DONE : REC_WAIT;
          end
          DONE: begin
            idx <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ram_sequence_controller.sv
// tb_ram_sequence_controller: randomized record/playback bench against a timing-formula and press-list model
module tb_ram_sequence_controller;
  localparam int H = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iniciar_reproducao = 1'b0;
  logic iniciar_gravacao = 1'b0;
  logic parar = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] botoes = '0;
  logic [3:0] movimento;
  logic movimento_valido, ocupado, fim, erro_botao;
  logic [3:0] mem [16];
  logic [3:0] addr_r = '0;
  logic pre_we = 1'b0;
  logic [3:0] pre_addr = '0, pre_data = '0;
  logic [3:0] ref_mem [16];
  logic [7:0] wr_log [256];
  int wr_n = 0, n_err = 0, n_fim = 0;
  int n_chk = 0, n_pass = 0;
  logic [3:0] pv [$];
  int ph [$];
  ram_sequence_controller_if bus ();
  ram_sequence_controller #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .iniciar_reproducao(iniciar_reproducao),
    .iniciar_gravacao(iniciar_gravacao), .parar(parar), .limite(limite), .botoes(botoes),
    .ram(bus.master), .movimento(movimento), .movimento_valido(movimento_valido),
    .ocupado(ocupado), .fim(fim), .erro_botao(erro_botao));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
    addr_r <= bus.ram_addr;
  end
  assign bus.ram_q = mem[addr_r];
  always @(negedge clk) begin
    if (bus.ram_we && wr_n < 256) wr_log[wr_n] <= {bus.ram_addr, bus.ram_data};
    if (bus.ram_we) wr_n <= wr_n + 1;
    if (erro_botao) n_err <= n_err + 1;
    if (fim) n_fim <= n_fim + 1;
  end
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", t, got, exp);
  endtask
  task automatic zeros(input string t);
    chk({t, "_mov"}, movimento, 0);
    chk({t, "_val"}, movimento_valido, 0);
    chk({t, "_ocu"}, ocupado, 0);
    chk({t, "_fim"}, fim, 0);
    chk({t, "_err"}, erro_botao, 0);
    chk({t, "_we"}, bus.ram_we, 0);
    chk({t, "_addr"}, bus.ram_addr, 0);
  endtask
  task automatic preload(input int i, input logic [3:0] v);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = 4'(i);
    pre_data = v;
    ref_mem[i] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask
  // step k occupies H+2 cycles after the start edge; the move is visible in its last H cycles
  task automatic play(input int lim, input bit both, input int pulse_at, input int ab_at, input bit ab_rst);
    int n, k, p, w0;
    logic ev;
    logic [3:0] em;
    n = (lim + 1) * (H + 2);
    @(negedge clk);
    w0 = wr_n;
    limite = 4'(lim);
    iniciar_reproducao = 1'b1;
    iniciar_gravacao = both;
    @(negedge clk);
    for (int c = 1; c <= n + 2; c++) begin
      k = (c - 1) / (H + 2);
      p = c - k * (H + 2);
      ev = c <= n && p >= 3;
      em = ev ? ref_mem[k[3:0]] : 4'd0;
      chk("pb_mov", movimento, em);
      chk("pb_val", movimento_valido, ev);
      chk("pb_fim", fim, c == n + 1);
      chk("pb_ocu", ocupado, c <= n + 1);
      chk("pb_addr", bus.ram_addr, c <= n ? k : (c == n + 1 ? lim : 0));
      if (c == ab_at) begin
        if (ab_rst) begin
          #2 reset = 1'b1;
          #1;
        end else begin
          parar = 1'b1;
          @(negedge clk);
        end
        zeros(ab_rst ? "rst" : "stop");
        reset = 1'b0;
        parar = 1'b0;
        @(negedge clk);
        chk("ab_fim", fim, 0);
        chk("ab_ocu", ocupado, 0);
        return;
      end
      limite = 4'($urandom);
      iniciar_reproducao = c == pulse_at;
      iniciar_gravacao = c == pulse_at;
      @(negedge clk);
    end
    chk("pb_nowr", wr_n - w0, 0);
  endtask
  // model: a write for each new one-hot level, an error for each new multi-bit level, until lim+1 writes
  task automatic rec(input int lim);
    logic [7:0] ea [16];
    logic [3:0] prev, v;
    int idx, en, e_err, w0, e0, f0;
    prev = '0; idx = 0; en = 0; e_err = 0;
    foreach (pv[i]) begin
      if (idx <= lim && pv[i] != prev && pv[i] != 0) begin
        if ($countones(pv[i]) == 1) begin
          ea[en] = {idx[3:0], pv[i]};
          en++;
          idx++;
        end else e_err++;
      end
      prev = pv[i];
    end
    while (idx <= lim) begin
      v = 4'd1 << $urandom_range(0, 3);
      pv.push_back(4'd0); ph.push_back(2);
      pv.push_back(v); ph.push_back(2);
      ea[en] = {idx[3:0], v};
      en++;
      idx++;
    end
    pv.push_back(4'd0); ph.push_back(2);
    @(negedge clk);
    w0 = wr_n; e0 = n_err; f0 = n_fim;
    botoes = '0;
    limite = 4'(lim);
    iniciar_gravacao = 1'b1;
    @(negedge clk);
    iniciar_gravacao = 1'b0;
    foreach (pv[i]) begin
      botoes = pv[i];
      limite = 4'($urandom);
      repeat (ph[i]) @(negedge clk);
    end
    for (int t = 0; t < 20 && ocupado; t++) @(negedge clk);
    chk("rec_idle", ocupado, 0);
    chk("rec_nwr", wr_n - w0, en);
    for (int i = 0; i < en; i++) begin
      if (w0 + i < wr_n) chk("rec_wr", wr_log[w0 + i], ea[i]);
      ref_mem[ea[i][7:4]] = ea[i][3:0];
    end
    chk("rec_err", n_err - e0, e_err);
    chk("rec_fim", n_fim - f0, 1);
    pv.delete();
    ph.delete();
  endtask
  task automatic rec_abort();
    int w0, f0;
    @(negedge clk);
    w0 = wr_n; f0 = n_fim;
    limite = 4'($urandom_range(1, 3));
    iniciar_gravacao = 1'b1;
    @(negedge clk);
    iniciar_gravacao = 1'b0;
    botoes = 4'b1000;
    @(posedge clk);
    #1 parar = 1'b1;
    @(negedge clk);
    chk("ab_wr_we", bus.ram_we, 0);
    chk("ab_wr_ocu", ocupado, 1);
    @(negedge clk);
    parar = 1'b0;
    botoes = '0;
    chk("ab_wr_idle", ocupado, 0);
    repeat (2) @(negedge clk);
    chk("ab_wr_nwr", wr_n - w0, 0);
    chk("ab_wr_fim", n_fim - f0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [3:0] v;
    int r;
    @(negedge clk);
    zeros("reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, i < 4 ? (i == 0 ? 4'd0 : 4'd1 << i) : 4'($urandom));
    play(3, 0, 0, 0, 0);
    pv = '{4'b0001, 4'b0000, 4'b0100}; ph = '{2, 2, 2};
    rec(1);
    play(1, 0, 0, 0, 0);
    pv = '{4'b0011, 4'b0001, 4'b0000, 4'b0100}; ph = '{3, 10, 2, 2};
    rec(1);
    play(2, 1, 9, 0, 0);
    play(3, 0, 0, (H + 2) + 4, 0);
    rec_abort();
    play(7, 0, 0, $urandom_range(1, 8 * (H + 2)), 1);
    play(15, 0, 0, 0, 0);
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < $urandom_range(3, 8); i++) begin
        r = $urandom_range(0, 3);
        v = r == 0 ? 4'd0 : (r == 3 ? 4'($urandom) : 4'd1 << $urandom_range(0, 3));
        pv.push_back(v);
        ph.push_back($urandom_range(2, 4));
      end
      rec($urandom_range(0, 5));
      r = $urandom_range(0, 15);
      play(r, 0, $urandom_range(1, (r + 1) * (H + 2)), 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
